if_stage: RTL and testbench

Instruction-fetch stage for the pipelined MIPS core. It owns the program counter, drives the word address into the 64-word instruction ROM, and captures the returned instruction into the IF/ID pipeline register for the decoder. It also handles hazard stalls and branch/jump redirects from EX, flags out-of-range and misaligned fetches, and keeps a fetch counter for bring-up.

---
 rtl/mips_pkg.sv | 9 +
 rtl/if_stage_if.sv | 24 ++
 rtl/if_stage.sv | 46 ++++
 tb/tb_if_stage.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, NOP encoding and fetch-stage defaults for the MIPS core.
package mips_pkg;
    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int DEFAULT_ROM_WORDS = 64;
    localparam int ROM_IDX_W = $clog2(DEFAULT_ROM_WORDS);
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: ROM, hazard/redirect and IF/ID signals of the fetch stage.
interface if_stage_if;
    import mips_pkg::*;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0] rom_inst;
    logic              id_valid;
    logic [INST_W-1:0] id_inst;
    logic [ADDR_W-1:0] id_pc;
    logic [ADDR_W-1:0] id_pc4;
    logic              id_badaddr;
    logic              align_err;
    logic [31:0]       fetch_count;
    modport master (
        input  stall, redirect_valid, redirect_pc, rom_inst,
        output rom_addr, id_valid, id_inst, id_pc, id_pc4, id_badaddr, align_err, fetch_count
    );
    modport slave (
        output stall, redirect_valid, redirect_pc, rom_inst,
        input  rom_addr, id_valid, id_inst, id_pc, id_pc4, id_badaddr, align_err, fetch_count
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: program counter, ROM fetch and IF/ID register with stall, redirect and range checks.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int ROM_WORDS = DEFAULT_ROM_WORDS
) (
    input logic clock,
    input logic reset,
    if_stage_if.master bus
);
    localparam logic [ADDR_W-3:0] ROM_LIM = (ADDR_W-2)'(ROM_WORDS);
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc4;
    logic              oor;
    assign pc4 = pc + ADDR_W'(4);
    assign oor = pc[ADDR_W-1:2] >= ROM_LIM;
    assign bus.rom_addr = pc;
    // Redirect beats stall so a taken branch is never lost behind a hazard hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc              <= RESET_PC;
            bus.id_valid    <= 1'b0;
            bus.id_inst     <= NOP_INST;
            bus.id_pc       <= '0;
            bus.id_pc4      <= '0;
            bus.id_badaddr  <= 1'b0;
            bus.align_err   <= 1'b0;
            bus.fetch_count <= '0;
        end else if (bus.redirect_valid) begin
            pc             <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            bus.id_valid   <= 1'b0;
            bus.id_inst    <= NOP_INST;
            bus.id_badaddr <= 1'b0;
            if (bus.redirect_pc[1:0] != 2'b00) bus.align_err <= 1'b1;
        end else if (!bus.stall) begin
            pc              <= pc4;
            bus.id_valid    <= 1'b1;
            bus.id_inst     <= oor ? NOP_INST : bus.rom_inst;
            bus.id_pc       <= pc;
            bus.id_pc4      <= pc4;
            bus.id_badaddr  <= oor;
            bus.fetch_count <= bus.fetch_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed stimulus with a rule-level fetch model checked every cycle.
module tb_if_stage;
    logic clk = 1'b0;
    logic rst, rst2;
    int checks = 0;
    int errors = 0;
    logic [31:0] rom [64];
    always #5 clk = ~clk;

    if_stage_if b();
    if_stage_if b2();
    if_stage #(.RESET_PC(32'h0000_0000), .ROM_WORDS(64)) dut (.clock(clk), .reset(rst), .bus(b));
    if_stage #(.RESET_PC(32'hFFFF_FFFC), .ROM_WORDS(64)) dut2 (.clock(clk), .reset(rst2), .bus(b2));

    // Out-of-range reads return garbage so NOP substitution is visible.
    assign b.rom_inst  = (b.rom_addr < 32'd256) ? rom[b.rom_addr[7:2]] : 32'hDEAD_BEEF;
    assign b2.rom_inst = (b2.rom_addr < 32'd256) ? rom[b2.rom_addr[7:2]] : 32'hDEAD_BEEF;
    assign b2.stall = 1'b0;
    assign b2.redirect_valid = 1'b0;
    assign b2.redirect_pc = 32'h0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks = checks + 1;
        if (a !== e) begin
            errors = errors + 1;
            $display("FAIL %s got %h want %h", n, a, e);
        end
    endtask

    logic        m_init = 1'b0;
    logic [31:0] m_pc, m_inst, m_idpc, m_pc4, m_cnt;
    logic        m_valid, m_bad, m_align;
    always @(posedge clk) begin
        if (rst) begin
            m_init <= 1'b1;
            m_pc <= 32'h0; m_valid <= 1'b0; m_inst <= 32'h0; m_idpc <= 32'h0;
            m_pc4 <= 32'h0; m_bad <= 1'b0; m_align <= 1'b0; m_cnt <= 32'h0;
        end else if (b.redirect_valid) begin
            m_pc <= b.redirect_pc & ~32'd3;
            m_valid <= 1'b0; m_inst <= 32'h0; m_bad <= 1'b0;
            if (b.redirect_pc % 4 != 0) m_align <= 1'b1;
        end else if (!b.stall) begin
            m_inst <= (m_pc < 32'd256) ? rom[m_pc / 4] : 32'h0;
            m_bad <= !(m_pc < 32'd256);
            m_valid <= 1'b1; m_idpc <= m_pc; m_pc4 <= m_pc + 4;
            m_pc <= m_pc + 4; m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("rom_addr", b.rom_addr, m_pc);
            chk("id_valid", 32'(b.id_valid), 32'(m_valid));
            chk("id_inst", b.id_inst, m_inst);
            chk("id_pc", b.id_pc, m_idpc);
            chk("id_pc4", b.id_pc4, m_pc4);
            chk("id_badaddr", 32'(b.id_badaddr), 32'(m_bad));
            chk("align_err", 32'(b.align_err), 32'(m_align));
            chk("fetch_count", b.fetch_count, m_cnt);
        end
    end

    task automatic go(input logic r, input logic s, input logic v, input logic [31:0] p);
        rst = r; b.stall = s; b.redirect_valid = v; b.redirect_pc = p;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h2000_0000 + i;
        rom[0] = 32'h3C03C000; rom[1] = 32'h3C04A000; rom[2] = 32'h8C850000;
        rst2 = 1'b1;
        go(1, 0, 0, 0);
        go(1, 0, 0, 0);
        chk("lit reset rom_addr", b.rom_addr, 32'h0);
        chk("lit reset id_valid", 32'(b.id_valid), 32'h0);
        chk("lit reset count", b.fetch_count, 32'h0);
        go(0, 0, 0, 0);
        chk("lit e1 inst", b.id_inst, 32'h3C03C000);
        chk("lit e1 pc4", b.id_pc4, 32'h4);
        chk("lit e1 rom_addr", b.rom_addr, 32'h4);
        go(0, 0, 0, 0);
        chk("lit e2 inst", b.id_inst, 32'h3C04A000);
        chk("lit e2 count", b.fetch_count, 32'h2);
        go(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            go(0, 1, 0, 0);
            chk("lit stall id_pc", b.id_pc, 32'h8);
            chk("lit stall inst", b.id_inst, 32'h8C850000);
            chk("lit stall rom_addr", b.rom_addr, 32'hC);
            chk("lit stall count", b.fetch_count, 32'h3);
        end
        go(0, 0, 0, 0);
        chk("lit resume id_pc", b.id_pc, 32'hC);
        go(0, 1, 1, 32'h34);
        chk("lit redir rom_addr", b.rom_addr, 32'h34);
        chk("lit redir valid", 32'(b.id_valid), 32'h0);
        chk("lit redir id_pc held", b.id_pc, 32'hC);
        go(0, 0, 0, 0);
        chk("lit target id_pc", b.id_pc, 32'h34);
        chk("lit target inst", b.id_inst, 32'h2000_000D);
        go(0, 0, 1, 32'h66);
        chk("lit misalign pc", b.rom_addr, 32'h64);
        chk("lit align_err", 32'(b.align_err), 32'h1);
        go(0, 0, 0, 0);
        go(0, 0, 1, 32'hFC);
        go(0, 0, 0, 0);
        chk("lit last word inst", b.id_inst, 32'h2000_003F);
        go(0, 0, 0, 0);
        chk("lit oor inst", b.id_inst, 32'h0);
        chk("lit oor bad", 32'(b.id_badaddr), 32'h1);
        chk("lit oor valid", 32'(b.id_valid), 32'h1);
        chk("lit align sticky", 32'(b.align_err), 32'h1);
        go(0, 1, 0, 0);
        go(0, 0, 0, 0);
        go(1, 1, 1, 32'h40);
        chk("lit mid reset pc", b.rom_addr, 32'h0);
        chk("lit mid reset count", b.fetch_count, 32'h0);
        chk("lit mid reset align", 32'(b.align_err), 32'h0);
        go(0, 0, 0, 0);
        go(0, 0, 0, 0);
        chk("lit wrap reset pc", b2.rom_addr, 32'hFFFF_FFFC);
        rst2 = 1'b0;
        @(negedge clk);
        chk("lit wrap pc", b2.rom_addr, 32'h0);
        chk("lit wrap id_pc", b2.id_pc, 32'hFFFF_FFFC);
        chk("lit wrap pc4", b2.id_pc4, 32'h0);
        chk("lit wrap bad", 32'(b2.id_badaddr), 32'h1);
        chk("lit wrap inst", b2.id_inst, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
